// File: rtl/avr_io_ctrl_pkg.sv
// Purpose : shared constants and helpers for the AVR I/O controller slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: register offsets, button count, default debounce length and
// a lowest-set-bit priority encoder used for the interrupt vector.
package avr_io_ctrl_pkg;

  localparam int NUM_BUTTONS             = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

  // Register offsets relative to BASE_ADDR
  localparam logic [1:0] REG_LEDS = 2'd0;
  localparam logic [1:0] REG_BTN  = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_IEN  = 2'd3;

  typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input btn_vec_t v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/avr_io_debounce.sv
// Purpose : one-button 2-flop synchronizer followed by a stable-count debouncer.
// Latency : a stable raw change shows on db after 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; free-running per clock.
//
// Ports: clk, reset (async, active-high), raw (asynchronous button),
//        db (debounced, registered).
module avr_io_debounce
  import avr_io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  // Keep at least one counter bit so DEBOUNCE_CYCLES=1 still elaborates.
  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b00;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) begin
        // Any agreement restarts the stability window.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/avr_io_ctrl.sv
// Purpose : AVR I/O-mapped LED/button block: LEDS, BTN, EDGE (W1C) and IEN registers + irq.
// Latency : reads combinational; writes on the io_we edge; irq/irq_vec one cycle behind pending.
// Backpressure: none; the I/O bus never stalls.
//
// Ports: clk, reset (async, active-high); io_addr/io_re/io_we/io_di/io_do core bus;
//        buttons (raw), leds; irq, irq_vec, irq_ack interrupt handshake.
module avr_io_ctrl
  import avr_io_ctrl_pkg::*;
#(
  parameter logic [5:0] BASE_ADDR       = 6'h18,
  parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             io_addr,
  input  logic                   io_re,
  input  logic                   io_we,
  input  logic [7:0]             io_di,
  output logic [7:0]             io_do,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [7:0]             leds,
  output logic                   irq,
  output logic [2:0]             irq_vec,
  input  logic                   irq_ack
);

  btn_vec_t   btn_db;
  btn_vec_t   btn_db_q;
  btn_vec_t   edge_r;
  btn_vec_t   ien_r;
  btn_vec_t   pending;
  btn_vec_t   w1c;
  btn_vec_t   ack_clr;
  btn_vec_t   edge_rise;
  logic [6:0] addr_off;
  logic       addr_hit;
  logic [1:0] reg_sel;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    avr_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (buttons[i]),
      .db    (btn_db[i])
    );
  end

  // 7-bit subtract so addresses below BASE_ADDR wrap far out of range.
  assign addr_off = {1'b0, io_addr} - {1'b0, BASE_ADDR};
  assign addr_hit = (addr_off < 7'd4);
  assign reg_sel  = addr_off[1:0];

  always_comb begin
    io_do = 8'h00;
    if (io_re && addr_hit) begin
      case (reg_sel)
        REG_LEDS: io_do = leds;
        REG_BTN:  io_do = 8'(btn_db);
        REG_EDGE: io_do = 8'(edge_r);
        REG_IEN:  io_do = 8'(ien_r);
        default:  io_do = 8'h00;
      endcase
    end
  end

  assign pending   = edge_r & ien_r;
  assign edge_rise = btn_db & ~btn_db_q;
  assign w1c       = (io_we && addr_hit && reg_sel == REG_EDGE) ? io_di[NUM_BUTTONS-1:0] : '0;

  // Ack only clears the vector it refers to, and only while that bit is still pending.
  always_comb begin
    ack_clr = '0;
    if (irq_ack && irq && pending[irq_vec]) ack_clr[irq_vec] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds     <= 8'h00;
      ien_r    <= '0;
      edge_r   <= '0;
      btn_db_q <= '0;
      irq      <= 1'b0;
      irq_vec  <= 3'd0;
    end else begin
      if (io_we && addr_hit && reg_sel == REG_LEDS) leds  <= io_di;
      if (io_we && addr_hit && reg_sel == REG_IEN)  ien_r <= io_di[NUM_BUTTONS-1:0];
      btn_db_q <= btn_db;
      // New rising edges are OR-ed in after the clears so a same-cycle set wins.
      edge_r   <= (edge_r & ~(w1c | ack_clr)) | edge_rise;
      irq      <= |pending;
      irq_vec  <= lowest_set(pending);
    end
  end

endmodule

// File: tb/tb_avr_io_ctrl.sv
module tb_avr_io_ctrl;

  localparam int         D    = 4;
  localparam logic [5:0] BASE = 6'h18;
  localparam int         NV   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] io_addr;
  logic       io_re, io_we;
  logic [7:0] io_di, io_do;
  logic [4:0] buttons;
  logic [7:0] leds;
  logic       irq;
  logic [2:0] irq_vec;
  logic       irq_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avr_io_ctrl #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_addr (io_addr),
    .io_re   (io_re),
    .io_we   (io_we),
    .io_di   (io_di),
    .io_do   (io_do),
    .buttons (buttons),
    .leds    (leds),
    .irq     (irq),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack)
  );

  typedef struct {
    logic       we;
    logic       re;
    logic [5:0] addr;
    logic [7:0] di;
    logic [7:0] exp_do;
    logic [7:0] exp_leds;
  } vec_t;

  vec_t tbl[NV];

  // ---------------- reference model ----------------
  logic [7:0] m_leds;
  logic [4:0] m_btn, m_edge, m_ien, m_rise;
  logic       m_irq;
  logic [2:0] m_vec;
  logic [4:0] m_hist[$];   // raw button samples, oldest first

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_leds = 8'h00; m_btn = 5'd0; m_edge = 5'd0; m_ien = 5'd0; m_rise = 5'd0;
    m_irq = 1'b0; m_vec = 3'd0;
    m_hist.delete();
    for (int i = 0; i < D + 1; i++) m_hist.push_back(5'd0);
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a, input logic re);
    int off;
    off = int'(a) - int'(BASE);
    if (!re || off < 0 || off > 3) return 8'h00;
    case (off)
      0:       return m_leds;
      1:       return {3'b000, m_btn};
      2:       return {3'b000, m_edge};
      default: return {3'b000, m_ien};
    endcase
  endfunction

  // One clock of the specified behaviour, using the inputs sampled at this edge.
  task automatic m_update();
    logic [4:0] pend, clr, btn_new;
    int         off;
    bit         all_diff;
    if (reset) begin
      m_reset();
      return;
    end
    pend = m_edge & m_ien;
    off  = int'(io_addr) - int'(BASE);
    clr  = (io_we && off == 2) ? io_di[4:0] : 5'd0;
    if (irq_ack && m_irq && pend[m_vec]) clr[m_vec] = 1'b1;
    m_hist.push_back(buttons);
    if (m_hist.size() > D + 2) void'(m_hist.pop_front());
    // A button flips once the D raw samples seen through the 2-cycle
    // synchronizer delay all disagree with its current debounced value.
    btn_new = m_btn;
    for (int b = 0; b < 5; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[j][b] == m_btn[b]) all_diff = 1'b0;
      if (all_diff) btn_new[b] = ~m_btn[b];
    end
    m_edge = (m_edge & ~clr) | m_rise;
    m_rise = btn_new & ~m_btn;
    m_btn  = btn_new;
    m_irq  = |pend;
    m_vec  = 3'd0;
    for (int i = 4; i >= 0; i--) if (pend[i]) m_vec = 3'(i);
    if (io_we && off == 0) m_leds = io_di;
    if (io_we && off == 3) m_ien  = io_di[4:0];
  endtask

  task automatic step();
    @(posedge clk);
    m_update();
    #1;
    check("model leds", leds, m_leds);
    check("model irq", {7'd0, irq}, {7'd0, m_irq});
    check("model irq_vec", {5'd0, irq_vec}, {5'd0, m_vec});
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_we = 1'b1; io_addr = a; io_di = d;
    step();
    io_we = 1'b0; io_di = 8'h00;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] v);
    io_re = 1'b1; io_addr = a;
    #1;
    v = io_do;
    io_re = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [5:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    check(name, v, exp);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 6'h18, 8'hA5, 8'h00, 8'hA5};
    tbl[1]  = '{1'b0, 1'b1, 6'h18, 8'h00, 8'hA5, 8'hA5};
    tbl[2]  = '{1'b0, 1'b1, 6'h3F, 8'h00, 8'h00, 8'hA5};
    tbl[3]  = '{1'b1, 1'b0, 6'h19, 8'hFF, 8'h00, 8'hA5};
    tbl[4]  = '{1'b0, 1'b1, 6'h19, 8'h00, 8'h00, 8'hA5};
    tbl[5]  = '{1'b1, 1'b0, 6'h1B, 8'hFF, 8'h00, 8'hA5};
    tbl[6]  = '{1'b0, 1'b1, 6'h1B, 8'h00, 8'h1F, 8'hA5};
    tbl[7]  = '{1'b1, 1'b0, 6'h1C, 8'h55, 8'h00, 8'hA5};
    tbl[8]  = '{1'b0, 1'b1, 6'h18, 8'h00, 8'hA5, 8'hA5};
    tbl[9]  = '{1'b0, 1'b1, 6'h17, 8'h00, 8'h00, 8'hA5};
    tbl[10] = '{1'b0, 1'b1, 6'h1C, 8'h00, 8'h00, 8'hA5};
    tbl[11] = '{1'b1, 1'b1, 6'h18, 8'h3C, 8'hA5, 8'h3C};
    tbl[12] = '{1'b0, 1'b1, 6'h1A, 8'h00, 8'h00, 8'h3C};
    tbl[13] = '{1'b1, 1'b0, 6'h1B, 8'h00, 8'h00, 8'h3C};
    tbl[14] = '{1'b0, 1'b1, 6'h1B, 8'h00, 8'h00, 8'h3C};
    tbl[15] = '{1'b1, 1'b0, 6'h18, 8'hA5, 8'h00, 8'hA5};

    reset = 1'b0; io_addr = 6'h00; io_re = 1'b0; io_we = 1'b0; io_di = 8'h00;
    buttons = 5'd0; irq_ack = 1'b0;
    #1 reset = 1'b1;
    m_reset();
    #1;
    check("reset leds", leds, 8'h00);
    check("reset irq", {7'd0, irq}, 8'h00);
    check("reset irq_vec", {5'd0, irq_vec}, 8'h00);
    step(); step();
    reset = 1'b0;
    chk_reg("reset EDGE", 6'h1A, 8'h00);
    chk_reg("reset IEN", 6'h1B, 8'h00);
    chk_reg("reset BTN", 6'h19, 8'h00);

    // Register access table
    for (int i = 0; i < NV; i++) begin
      io_we = tbl[i].we; io_re = tbl[i].re; io_addr = tbl[i].addr; io_di = tbl[i].di;
      #1;
      check($sformatf("vec%0d io_do", i), io_do, tbl[i].exp_do);
      step();
      check($sformatf("vec%0d leds", i), leds, tbl[i].exp_leds);
      io_we = 1'b0; io_re = 1'b0; io_di = 8'h00;
    end

    // Short glitch on button 2 must not reach BTN or EDGE
    buttons[2] = 1'b1;
    step(); step(); step();
    buttons[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_reg("glitch BTN", 6'h19, 8'h00);
      chk_reg("glitch EDGE", 6'h1A, 8'h00);
    end

    // Held press: BTN after 6 cycles, EDGE one cycle later
    buttons[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_reg($sformatf("hold BTN c%0d", k), 6'h19, (k >= 6) ? 8'h04 : 8'h00);
      chk_reg($sformatf("hold EDGE c%0d", k), 6'h1A, (k >= 7) ? 8'h04 : 8'h00);
    end
    buttons[2] = 1'b0;
    repeat (8) step();
    chk_reg("release BTN", 6'h19, 8'h00);
    chk_reg("release EDGE kept", 6'h1A, 8'h04);
    wr(6'h1A, 8'hFF);
    chk_reg("w1c EDGE", 6'h1A, 8'h00);

    // Two pending buttons, priority and acknowledge
    wr(6'h1B, 8'h1F);
    buttons[3] = 1'b1;
    step(); step();
    buttons[1] = 1'b1;
    repeat (6) step();
    check("irq btn3", {7'd0, irq}, 8'h01);
    check("vec btn3", {5'd0, irq_vec}, 8'h03);
    step(); step();
    chk_reg("EDGE both", 6'h1A, 8'h0A);
    check("irq both", {7'd0, irq}, 8'h01);
    check("vec both", {5'd0, irq_vec}, 8'h01);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk_reg("ack1 EDGE", 6'h1A, 8'h08);
    step();
    check("ack1 vec", {5'd0, irq_vec}, 8'h03);
    check("ack1 irq", {7'd0, irq}, 8'h01);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk_reg("ack2 EDGE", 6'h1A, 8'h00);
    step();
    check("ack2 irq", {7'd0, irq}, 8'h00);
    check("ack2 vec", {5'd0, irq_vec}, 8'h00);
    buttons[3] = 1'b0; buttons[1] = 1'b0;
    repeat (8) step();

    // W1C on the same edge that latches a new rise: set wins
    buttons[0] = 1'b1;
    repeat (6) step();
    chk_reg("pre-set EDGE", 6'h1A, 8'h00);
    wr(6'h1A, 8'h01);
    chk_reg("set wins EDGE", 6'h1A, 8'h01);
    buttons[0] = 1'b0;
    repeat (8) step();

    // Reset in the middle of a debounce
    wr(6'h18, 8'hFF);
    buttons[4] = 1'b1;
    repeat (4) step();
    check("pre-reset irq", {7'd0, irq}, 8'h01);
    check("pre-reset leds", leds, 8'hFF);
    reset = 1'b1;
    m_reset();
    #1;
    check("async leds", leds, 8'h00);
    check("async irq", {7'd0, irq}, 8'h00);
    check("async irq_vec", {5'd0, irq_vec}, 8'h00);
    chk_reg("async EDGE", 6'h1A, 8'h00);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_reg($sformatf("post-rst BTN c%0d", k), 6'h19, (k >= 6) ? 8'h10 : 8'h00);
      chk_reg($sformatf("post-rst EDGE c%0d", k), 6'h1A, (k >= 7) ? 8'h10 : 8'h00);
    end
    wr(6'h1A, 8'h10);
    repeat (5) step();
    chk_reg("single edge", 6'h1A, 8'h00);
    chk_reg("held BTN", 6'h19, 8'h10);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(15) == 0) buttons[b] = ~buttons[b];
      io_we   = ($urandom_range(3) == 0);
      io_re   = ($urandom_range(1) == 1);
      io_addr = 6'h16 + 6'($urandom_range(7));
      io_di   = 8'($urandom);
      irq_ack = ($urandom_range(4) == 0);
      #1;
      check("rand io_do", io_do, m_read(io_addr, io_re));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avr_io_ctrl.md
AVR_IO_CTRL -- requirements
Module: avr_io_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 6'h18: I/O address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000: consecutive stable cycles required before a debounced button changes.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_addr  input  6  AVR I/O bus address.
REQ-006 io_re  input  1  read strobe.
REQ-007 io_we  input  1  write strobe.
REQ-008 io_di  input  8  write data from the core.
REQ-009 io_do  output  8  read data to the core.
REQ-010 buttons  input  5  raw asynchronous push-buttons.
REQ-011 leds  output  8  LED drive.
REQ-012 irq  output  1  interrupt request, level.
REQ-013 irq_vec  output  3  index of the lowest-numbered pending enabled button.
REQ-014 irq_ack  input  1  single-cycle interrupt acknowledge from the core.

Function
REQ-015 Register map (offset from BASE_ADDR):
- 0 LEDS: read/write; drives leds.
- 1 BTN: read-only; debounced state in bits [4:0], bits [7:5] read 0.
- 2 EDGE: rising-edge latches in [4:0]; write-1-to-clear.
- 3 IEN: interrupt enables in [4:0], read/write.
REQ-016 io_do is combinational and valid in the io_re cycle. It returns 8'h00 when io_re=0 or io_addr is outside the decoded range.
REQ-017 Writes take effect on the clk edge where io_we=1. Writes to BTN, undecoded addresses, and bits [7:5] of EDGE and IEN have no effect.
REQ-018 Each button passes through a 2-flop synchronizer before debounce.
REQ-019 Per-button debounce counter behaviour:
- Clears whenever the synchronized input equals the debounced state.
- Otherwise increments.
- On reaching DEBOUNCE_CYCLES-1 while still different, the debounced bit takes the new value and the counter clears.
- Counter width is $clog2(DEBOUNCE_CYCLES).
REQ-020 Total latency from a stable raw change to the BTN bit change is 2 + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES never changes BTN.
REQ-021 A 0->1 transition of a debounced bit sets the matching EDGE bit one cycle later. A 1->0 transition sets nothing.
REQ-022 If an edge set and a W1C clear hit the same EDGE bit in the same cycle, the set wins.
REQ-023 pending = EDGE & IEN. irq is registered: irq = |pending, updated every cycle, so it is 1 cycle behind pending.
REQ-024 irq_vec is registered alongside irq and holds the lowest index with pending=1. It is 0 when nothing is pending.
REQ-025 irq_ack=1 clears the EDGE bit selected by the current irq_vec, but only if that bit is still pending. irq_ack with irq=0 is ignored.
REQ-026 If irq_ack and a W1C write arrive in the same cycle, both clears apply (union). A simultaneous new edge still wins per REQ-022.
REQ-027 Clearing IEN bits drops the related request from irq on the next cycle without altering EDGE.

Reset
REQ-028 On reset assertion, immediately and independent of clk:
- leds = 0, irq = 0, irq_vec = 0
- EDGE = 0, IEN = 0
- debounced state = 0, synchronizers = 0, all counters = 0
REQ-029 Reset asserted mid-debounce discards partial counts. After release, a held button needs the full 2 + DEBOUNCE_CYCLES cycles to appear in BTN, and it produces one EDGE set.
REQ-030 Reset is released synchronously to clk by the system; the block adds no internal reset synchronizer.

Structure
REQ-031 A shared package holds:
- register offset constants (LEDS, BTN, EDGE, IEN)
- NUM_BUTTONS = 5
- the default DEBOUNCE_CYCLES
REQ-032 One sub-module, avr_io_debounce: 1-bit synchronizer plus counter plus debounced output, parameterized by DEBOUNCE_CYCLES, instantiated NUM_BUTTONS times.
REQ-033 The top level contains the register file, read mux, edge detect, pending priority encoder and irq registers.

Verification (DEBOUNCE_CYCLES=4, BASE_ADDR=6'h18)
REQ-034 Write 8'hA5 to 6'h18, then read 6'h18 -> io_do=8'hA5 and leds=8'hA5; read 6'h3F -> 8'h00.
REQ-035 Raise buttons[2] for 3 cycles and drop it -> BTN stays 0 and EDGE stays 0. Hold it for 10 cycles -> BTN=8'h04 exactly 6 cycles after the rise, and EDGE=8'h04 one cycle later.
REQ-036 With IEN=8'h1F, press buttons[3] then buttons[1] -> irq=1. Check:
- irq_vec=1 while EDGE=8'h0A.
- irq_ack -> EDGE=8'h08 and irq_vec=3.
- irq_ack -> EDGE=0 and irq=0 one cycle later.
REQ-037 Write 8'h01 to EDGE in the same cycle a new buttons[0] edge latches -> EDGE bit 0 remains 1.
REQ-038 Assert reset during the 3rd debounce cycle of a held buttons[4] -> all outputs go to 0 immediately. After release, BTN=8'h10 after 6 more cycles, with exactly one EDGE set.
